// File: rtl/scsp_lfo_bank.sv
// Time-multiplexed SCSP LFO engine: per-slot phase/divider state lives in RAM and one
// slot is advanced per accepted request through a two-stage pipeline.
module scsp_lfo_bank #(
    parameter int          SLOTS      = 32,
    parameter logic [15:0] NOISE_SEED = 16'h0001,
    parameter bit          KON_SYNC   = 1'b1,
    localparam int         SW         = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CE,
    input  logic          REQ,
    input  logic [SW-1:0] REQ_SLOT,
    input  logic          LFORE,
    input  logic          KON,
    input  logic [4:0]    LFOF,
    input  logic [1:0]    PLFOWS,
    input  logic [2:0]    PLFOS,
    input  logic [1:0]    ALFOWS,
    input  logic [2:0]    ALFOS,
    output logic          BUSY,
    output logic          OUT_VALID,
    output logic [SW-1:0] OUT_SLOT,
    output logic [7:0]    ALFO,
    output logic [7:0]    PLFO
);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef struct packed {
        logic          valid;
        logic [SW-1:0] slot;
        logic          lfore;
        logic          kon;
        logic [4:0]    lfof;
        logic [1:0]    pitch_ws;
        logic [2:0]    pitch_depth;
        logic [1:0]    amp_ws;
        logic [2:0]    amp_depth;
        logic [7:0]    noise;
        logic [7:0]    phase;
        logic [9:0]    divcnt;
    } s1_t;

    logic [7:0]    phase_mem [SLOTS];
    logic [9:0]    div_mem   [SLOTS];

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] clr_ptr_q, clr_ptr_d;
    logic [15:0]   lfsr_q, lfsr_d;
    s1_t           s1_q, s1_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_slot_q, out_slot_d;
    logic [7:0]    alfo_q, alfo_d;
    logic [7:0]    plfo_q, plfo_d;

    logic          accept;
    logic          fwd;
    logic          fb;
    logic          mem_we;
    logic [SW-1:0] mem_addr;
    logic [7:0]    mem_phase_wd;
    logic [9:0]    mem_div_wd;
    logic [3:0]    rl_base;
    logic [11:0]   rl_shift;
    logic [9:0]    reload;
    logic [7:0]    p;
    logic [7:0]    wa;
    logic [7:0]    wp;
    logic signed [7:0] wp_s;
    logic signed [7:0] plfo_sh;
    logic [7:0]    alfo_calc;
    logic [7:0]    plfo_calc;
    logic [7:0]    new_phase;
    logic [9:0]    new_div;

    assign BUSY      = (state_q == ST_CLEAR);
    assign OUT_VALID = out_valid_q;
    assign OUT_SLOT  = out_slot_q;
    assign ALFO      = alfo_q;
    assign PLFO      = plfo_q;

    assign accept = CE && REQ && (state_q == ST_RUN);
    assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Stage 2: waveform shaping and per-slot state update from the pre-update phase.
    always_comb begin
        rl_base  = {1'b0, ~{1'b0, s1_q.lfof[1:0]}} + 4'd1;
        rl_shift = ({8'd0, rl_base} << 7) >> s1_q.lfof[4:2];
        reload   = 10'(rl_shift - 12'd5);
        p        = s1_q.phase;

        case (s1_q.amp_ws)
            2'd0:    wa = p;
            2'd1:    wa = {8{p[7]}};
            2'd2:    wa = {p[6:0] ^ {7{p[7]}}, 1'b0};
            default: wa = s1_q.noise;
        endcase
        alfo_calc = (s1_q.amp_depth == 3'd0) ? 8'd0 : ((wa & 8'hFE) >> (3'd7 - s1_q.amp_depth));

        case (s1_q.pitch_ws)
            2'd0:    wp = p;
            2'd1:    wp = {p[7], {7{~p[7]}}};
            2'd2:    wp = {{1'b0, p[5:0] ^ {6{p[6]}}} ^ {7{p[7]}}, 1'b0};
            default: wp = s1_q.noise ^ 8'h80;
        endcase
        // Shift kept in its own signed statement so the ternary cannot force it unsigned.
        wp_s      = wp & 8'hFE;
        plfo_sh   = wp_s >>> (3'd7 - s1_q.pitch_depth);
        plfo_calc = (s1_q.pitch_depth == 3'd0) ? 8'd0 : plfo_sh;

        if (s1_q.lfore || (s1_q.kon && KON_SYNC)) begin
            new_phase = 8'd0;
            new_div   = reload;
        end else if (s1_q.divcnt == 10'd0) begin
            new_phase = p + 8'd1;
            new_div   = reload;
        end else begin
            new_phase = p;
            new_div   = s1_q.divcnt - 10'd1;
        end
    end

    // FSM, RAM write port (clear sweep or stage-2 writeback) and noise LFSR.
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        lfsr_d       = lfsr_q;
        mem_we       = 1'b0;
        mem_addr     = clr_ptr_q;
        mem_phase_wd = 8'd0;
        mem_div_wd   = 10'd0;
        if (CE) begin
            if (state_q == ST_CLEAR) begin
                mem_we = 1'b1;
                if (clr_ptr_q == SW'(SLOTS - 1)) begin
                    state_d   = ST_RUN;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + SW'(1);
                end
            end else if (s1_q.valid) begin
                mem_we       = 1'b1;
                mem_addr     = s1_q.slot;
                mem_phase_wd = new_phase;
                mem_div_wd   = new_div;
            end
            if (accept) begin
                lfsr_d = {lfsr_q[14:0], fb};
            end
        end
    end

    // Stage 1 capture with same-slot forwarding from the write happening this edge.
    always_comb begin
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        out_slot_d  = out_slot_q;
        alfo_d      = alfo_q;
        plfo_d      = plfo_q;
        fwd         = s1_q.valid && (s1_q.slot == REQ_SLOT);
        if (CE) begin
            s1_d.valid = accept;
            if (accept) begin
                s1_d.slot        = REQ_SLOT;
                s1_d.lfore       = LFORE;
                s1_d.kon         = KON;
                s1_d.lfof        = LFOF;
                s1_d.pitch_ws    = PLFOWS;
                s1_d.pitch_depth = PLFOS;
                s1_d.amp_ws      = ALFOWS;
                s1_d.amp_depth   = ALFOS;
                s1_d.noise       = lfsr_q[15:8];
                s1_d.phase       = fwd ? new_phase : phase_mem[REQ_SLOT];
                s1_d.divcnt      = fwd ? new_div : div_mem[REQ_SLOT];
            end
            out_valid_d = s1_q.valid;
            if (s1_q.valid) begin
                out_slot_d = s1_q.slot;
                alfo_d     = alfo_calc;
                plfo_d     = plfo_calc;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_CLEAR;
            clr_ptr_q   <= '0;
            lfsr_q      <= NOISE_SEED;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_slot_q  <= '0;
            alfo_q      <= 8'd0;
            plfo_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            lfsr_q      <= lfsr_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_slot_q  <= out_slot_d;
            alfo_q      <= alfo_d;
            plfo_q      <= plfo_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            phase_mem[mem_addr] <= mem_phase_wd;
            div_mem[mem_addr]   <= mem_div_wd;
        end
    end
endmodule

// File: tb/tb_scsp_lfo_bank.sv
// Directed bench for scsp_lfo_bank: two instances (KON_SYNC=1 and KON_SYNC=0) share stimulus.
module tb_scsp_lfo_bank;
    localparam int SW = 5;

    logic          CLK;
    logic          RST_N;
    logic          CE;
    logic          REQ;
    logic [SW-1:0] REQ_SLOT;
    logic          LFORE;
    logic          KON;
    logic [4:0]    LFOF;
    logic [1:0]    PLFOWS;
    logic [2:0]    PLFOS;
    logic [1:0]    ALFOWS;
    logic [2:0]    ALFOS;

    logic          busy_a, ov_a, busy_b, ov_b;
    logic [SW-1:0] os_a, os_b;
    logic [7:0]    alfo_a, plfo_a, alfo_b, plfo_b;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [20:0]   got_q[$];
    logic [20:0]   got2_q[$];
    logic [SW-1:0] r_slot;
    logic [7:0]    r_alfo, r_plfo, r2_alfo, r2_plfo;

    int            saw_exp[4] = '{0, 0, 2, 2};
    int            fwd_slot[5] = '{7, 7, 8, 7, 7};
    int            fwd_alfo[5] = '{0, 0, 0, 2, 2};

    scsp_lfo_bank u_dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .REQ(REQ), .REQ_SLOT(REQ_SLOT),
        .LFORE(LFORE), .KON(KON), .LFOF(LFOF), .PLFOWS(PLFOWS), .PLFOS(PLFOS),
        .ALFOWS(ALFOWS), .ALFOS(ALFOS), .BUSY(busy_a), .OUT_VALID(ov_a),
        .OUT_SLOT(os_a), .ALFO(alfo_a), .PLFO(plfo_a)
    );

    scsp_lfo_bank #(.KON_SYNC(1'b0)) u_dut_nosync (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .REQ(REQ), .REQ_SLOT(REQ_SLOT),
        .LFORE(LFORE), .KON(KON), .LFOF(LFOF), .PLFOWS(PLFOWS), .PLFOS(PLFOS),
        .ALFOWS(ALFOWS), .ALFOS(ALFOS), .BUSY(busy_b), .OUT_VALID(ov_b),
        .OUT_SLOT(os_b), .ALFO(alfo_b), .PLFO(plfo_b)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    // Result monitor, sampled on the falling edge
    always @(negedge CLK) begin
        if (RST_N && ov_a) got_q.push_back({os_a, alfo_a, plfo_a});
        if (RST_N && ov_b) got2_q.push_back({os_b, alfo_b, plfo_b});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int slot, input int lfof, input int a_ws, input int a_dp,
                           input int p_ws, input int p_dp, input bit lfore = 1'b0,
                           input bit kon = 1'b0);
        REQ      = 1'b1;
        REQ_SLOT = slot[SW-1:0];
        LFOF     = lfof[4:0];
        ALFOWS   = a_ws[1:0];
        ALFOS    = a_dp[2:0];
        PLFOWS   = p_ws[1:0];
        PLFOS    = p_dp[2:0];
        LFORE    = lfore;
        KON      = kon;
    endtask

    task automatic idle();
        REQ   = 1'b0;
        LFORE = 1'b0;
        KON   = 1'b0;
    endtask

    task automatic collect(input string tag);
        logic [20:0] e;
        int t = 0;
        while (got_q.size() == 0 && t < 20) begin
            @(negedge CLK);
            t++;
        end
        check({tag, "_arrive"}, 32'(got_q.size() > 0), 32'd1);
        if (got_q.size() > 0) begin
            e = got_q.pop_front();
            r_slot = e[20:16];
            r_alfo = e[15:8];
            r_plfo = e[7:0];
        end else begin
            r_slot = 'x;
            r_alfo = 'x;
            r_plfo = 'x;
        end
        if (got2_q.size() > 0) begin
            e = got2_q.pop_front();
            r2_alfo = e[15:8];
            r2_plfo = e[7:0];
        end else begin
            r2_alfo = 'x;
            r2_plfo = 'x;
        end
    endtask

    task automatic visit(input string tag, input int slot, input int lfof, input int a_ws,
                         input int a_dp, input int p_ws, input int p_dp,
                         input bit lfore = 1'b0, input bit kon = 1'b0);
        @(posedge CLK);
        #1;
        set_req(slot, lfof, a_ws, a_dp, p_ws, p_dp, lfore, kon);
        @(posedge CLK);
        #1;
        idle();
        collect(tag);
    endtask

    // Counts BUSY cycles after reset release while offering requests that must be ignored.
    task automatic sweep(input string tag);
        int cyc = 0;
        set_req(1, 31, 3, 7, 3, 7);
        while (busy_a && cyc < 100) begin
            REQ = (cyc < 8);
            @(posedge CLK);
            #1;
            cyc++;
        end
        idle();
        check({tag, "_busy_cycles"}, cyc, 32);
        repeat (4) @(negedge CLK);
        check({tag, "_busy_req_ignored"}, got_q.size(), 0);
    endtask

    initial begin
        RST_N = 1'b0; CE = 1'b1; REQ = 1'b0; LFORE = 1'b0; KON = 1'b0;
        REQ_SLOT = '0; LFOF = '0; PLFOWS = '0; PLFOS = '0; ALFOWS = '0; ALFOS = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", busy_a, 1);
        check("rst_busy_b", busy_b, 1);
        check("rst_out_valid", ov_a, 0);
        check("rst_out_slot", os_a, 0);
        check("rst_alfo", alfo_a, 0);
        check("rst_plfo", plfo_a, 0);
        RST_N = 1'b1;
        sweep("sweep1");

        // Noise: LFSR from seed 1 samples 1<<i for the i-th request up to i=10, then 0x0801
        for (int i = 0; i < 12; i++) begin
            visit("noise", 5, 31, 3, 7, 3, 7);
            if (i == 0) begin
                check("noise0_slot", r_slot, 5);
                check("noise0_alfo", r_alfo, 8'h00);
                check("noise0_plfo", r_plfo, 8'h80);
            end else if (i == 9) begin
                check("noise9_alfo", r_alfo, 8'h02);
                check("noise9_plfo", r_plfo, 8'h82);
            end else if (i == 10) begin
                check("noise10_alfo", r_alfo, 8'h04);
                check("noise10_plfo", r_plfo, 8'h84);
            end else if (i == 11) begin
                check("noise11_alfo", r_alfo, 8'h08);
                check("noise11_plfo", r_plfo, 8'h88);
            end
        end

        // Saw stepping and 8-bit phase wrap, slot 3, LFOF=31 (reload 0)
        for (int v = 1; v <= 259; v++) begin
            visit("saw", 3, 31, 0, 7, 0, 7);
            if (v <= 4) begin
                check("saw_alfo", r_alfo, saw_exp[v-1]);
                check("saw_plfo", r_plfo, saw_exp[v-1]);
                check("saw_slot", r_slot, 3);
            end else if (v == 256) begin
                check("saw255_alfo", r_alfo, 8'hFE);
                check("saw255_plfo", r_plfo, 8'hFE);
            end else if (v == 257) begin
                check("sawwrap_alfo", r_alfo, 8'h00);
            end else if (v == 259) begin
                check("sawwrap2_alfo", r_alfo, 8'h02);
            end
        end

        // Divider, slot 10, LFOF=0 (reload 1019), triangle exposes phase 0 vs 1
        for (int v = 1; v <= 1022; v++) begin
            visit("div", 10, 0, 2, 7, 0, 0);
            if (v == 1) begin
                check("div_v1_alfo", r_alfo, 8'h00);
                check("div_plfos0", r_plfo, 8'h00);
            end else if (v == 2) begin
                check("div_v2_alfo", r_alfo, 8'h02);
            end else if (v == 1021) begin
                check("div_v1021_alfo", r_alfo, 8'h02);
            end else if (v == 1022) begin
                check("div_v1022_alfo", r_alfo, 8'h04);
            end
        end

        // Forwarding: consecutive-cycle requests, slot 8 interleaved
        @(posedge CLK);
        #1;
        for (int k = 0; k < 5; k++) begin
            set_req(fwd_slot[k], 31, (fwd_slot[k] == 8) ? 2 : 0, 7, 0, 7);
            @(posedge CLK);
            #1;
        end
        idle();
        for (int k = 0; k < 5; k++) begin
            collect("fwd");
            check("fwd_slot", r_slot, fwd_slot[k]);
            check("fwd_alfo", r_alfo, fwd_alfo[k]);
        end
        visit("fwd8", 8, 31, 2, 7, 0, 7);
        check("fwd8_after_alfo", r_alfo, 8'h02);
        visit("fwd7", 7, 31, 0, 7, 0, 7);
        check("fwd7_after_alfo", r_alfo, 8'h04);

        // LFORE and KON on slot 2; second instance ignores KON
        for (int v = 1; v <= 44; v++) begin
            visit("kon", 2, 31, 0, 7, 0, 7, (v == 43), (v == 41));
            if (v == 41) begin
                check("kon_v41_sync", r_alfo, 8'h28);
                check("kon_v41_nosync", r2_alfo, 8'h28);
            end else if (v == 42) begin
                check("kon_v42_sync", r_alfo, 8'h00);
                check("kon_v42_nosync", r2_alfo, 8'h28);
            end else if (v == 43) begin
                check("lfore_v43_sync", r_alfo, 8'h00);
                check("lfore_v43_nosync", r2_alfo, 8'h2A);
            end else if (v == 44) begin
                check("lfore_v44_sync", r_alfo, 8'h00);
                check("lfore_v44_nosync", r2_alfo, 8'h00);
            end
        end

        // Waveforms and depths around phase 0x80, slot 12
        for (int v = 1; v <= 131; v++) begin
            if (v == 129) visit("depth", 12, 31, 1, 3, 1, 4);
            else if (v == 130) visit("depth", 12, 31, 2, 7, 2, 7);
            else if (v == 131) visit("depth", 12, 31, 0, 0, 0, 1);
            else visit("depth", 12, 31, 0, 7, 0, 7);
            if (v == 128) begin
                check("p7f_alfo", r_alfo, 8'h7E);
                check("p7f_plfo", r_plfo, 8'h7E);
            end else if (v == 129) begin
                check("p80_sq_alfo", r_alfo, 8'h0F);
                check("p80_sq_plfo", r_plfo, 8'hF0);
            end else if (v == 130) begin
                check("p81_tri_alfo", r_alfo, 8'hFC);
                check("p81_tri_plfo", r_plfo, 8'hFC);
            end else if (v == 131) begin
                check("p82_alfos0", r_alfo, 8'h00);
                check("p82_plfo_sra6", r_plfo, 8'hFE);
            end
        end

        // CE=0 freezes the pipeline with a request in stage 1
        @(posedge CLK);
        #1;
        set_req(12, 31, 0, 7, 0, 7);
        @(posedge CLK);
        #1;
        idle();
        CE = 1'b0;
        repeat (6) @(negedge CLK);
        check("ce_hold_no_out", got_q.size(), 0);
        check("ce_hold_valid", ov_a, 0);
        CE = 1'b1;
        collect("ce_resume");
        check("ce_resume_alfo", r_alfo, 8'h82);
        check("ce_resume_plfo", r_plfo, 8'h82);

        // Reset asserted while a result is on the outputs
        @(posedge CLK);
        #1;
        set_req(12, 31, 0, 7, 0, 7);
        @(posedge CLK);
        #1;
        idle();
        @(posedge CLK);
        #1;
        check("pre_rst_valid", ov_a, 1);
        check("pre_rst_alfo", alfo_a, 8'h84);
        RST_N = 1'b0;
        #1;
        check("mid_rst_valid", ov_a, 0);
        check("mid_rst_alfo", alfo_a, 8'h00);
        check("mid_rst_plfo", plfo_a, 8'h00);
        check("mid_rst_busy", busy_a, 1);
        #2;
        RST_N = 1'b1;
        sweep("sweep2");
        visit("post_rst", 12, 31, 2, 7, 3, 7);
        check("post_rst_cleared_alfo", r_alfo, 8'h00);
        check("post_rst_seed_plfo", r_plfo, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
